// File: rtl/dispatch_ctrl_pkg.sv
// Shared encodings for the dispatch controller: functional-unit select and stall reason.
package dispatch_ctrl_pkg;

  typedef enum logic [2:0] {
    FU_NONE = 3'b000,
    FU_ALU  = 3'b001,
    FU_LSQ  = 3'b010,
    FU_BRA  = 3'b100
  } fu_e;

  typedef enum logic [1:0] {
    STALL_NONE = 2'b00,
    STALL_ROB  = 2'b01,
    STALL_RS   = 2'b10
  } stall_e;

  function automatic logic is_valid_fu(input logic [2:0] fu);
    return (fu == FU_ALU) || (fu == FU_LSQ) || (fu == FU_BRA);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_rs_credit_counter.sv
// Credit counter for one reservation station: consumes on dispatch, refills on free,
// and snaps back to full on restore.
module rs_credit_counter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         restore,
  output logic [W-1:0] credit,
  output logic         nonzero
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic at_full;

  assign at_full = (credit == FULL);
  assign nonzero = (credit != '0);

  // A free with nothing outstanding is dropped; free and consume together cancel out.
  always_ff @(posedge clk) begin
    if (rst || restore)                credit <= FULL;
    else if (inc && !dec && !at_full)  credit <= credit + 1'b1;
    else if (dec && !inc)              credit <= credit - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && !restore) begin
      free_overflow: assert (!(inc && !dec && at_full));
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order dispatcher: one-entry hold register, ROB tag allocation and credit-gated
// routing to the ALU, LSQ and branch reservation stations.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned ROB_DEPTH    = 16,
  parameter int unsigned ROB_TAG_W    = 4,
  parameter int unsigned ALU_RS_DEPTH = 4,
  parameter int unsigned LSQ_DEPTH    = 8,
  parameter int unsigned BRA_RS_DEPTH = 4,
  parameter int unsigned PAYLOAD_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [2:0]           dec_futype,
  input  logic                 dec_rob_we,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 rob_commit,
  input  logic                 alu_free,
  input  logic                 lsq_free,
  input  logic                 bra_free,
  output logic                 alu_valid,
  output logic                 lsq_valid,
  output logic                 bra_valid,
  output logic [PAYLOAD_W-1:0] disp_payload,
  output logic [ROB_TAG_W-1:0] disp_rob_tag,
  output logic                 rob_alloc,
  output logic                 ill_inst,
  output logic [1:0]           stall_cause
);

  localparam int unsigned CNT_W  = ROB_TAG_W + 1;
  localparam int unsigned ALU_CW = $clog2(ALU_RS_DEPTH + 1);
  localparam int unsigned LSQ_CW = $clog2(LSQ_DEPTH + 1);
  localparam int unsigned BRA_CW = $clog2(BRA_RS_DEPTH + 1);

  localparam logic [CNT_W-1:0]  ROB_FULL = CNT_W'(ROB_DEPTH);
  localparam logic [ALU_CW-1:0] ALU_MAX  = ALU_CW'(ALU_RS_DEPTH);
  localparam logic [LSQ_CW-1:0] LSQ_MAX  = LSQ_CW'(LSQ_DEPTH);
  localparam logic [BRA_CW-1:0] BRA_MAX  = BRA_CW'(BRA_RS_DEPTH);

  logic                 hold_v;
  fu_e                  hold_fu;
  logic [PAYLOAD_W-1:0] hold_payload;
  logic [ROB_TAG_W-1:0] tail;
  logic [CNT_W-1:0]     rob_cnt;
  logic                 ill_q;

  logic [ALU_CW-1:0] alu_credit;
  logic [LSQ_CW-1:0] lsq_credit;
  logic [BRA_CW-1:0] bra_credit;
  logic              alu_nz, lsq_nz, bra_nz;

  logic   rob_full, credit_ok, fire, accept, dec_ok, commit_ok;
  stall_e stall;

  assign rob_full  = (rob_cnt == ROB_FULL);
  assign credit_ok = ((hold_fu == FU_ALU) && alu_nz) ||
                     ((hold_fu == FU_LSQ) && lsq_nz) ||
                     ((hold_fu == FU_BRA) && bra_nz);
  assign fire      = hold_v && !flush && !rob_full && credit_ok;
  assign dec_ready = !flush && (!hold_v || fire);
  assign accept    = dec_valid && dec_ready;
  assign dec_ok    = dec_rob_we && is_valid_fu(dec_futype);
  assign commit_ok = rob_commit && (rob_cnt != '0);

  assign alu_valid    = fire && (hold_fu == FU_ALU);
  assign lsq_valid    = fire && (hold_fu == FU_LSQ);
  assign bra_valid    = fire && (hold_fu == FU_BRA);
  assign rob_alloc    = fire;
  assign disp_rob_tag = tail;
  assign disp_payload = fire ? hold_payload : '0;
  assign ill_inst     = ill_q;

  always_comb begin
    stall = STALL_NONE;
    if (hold_v && !flush && !fire) stall = rob_full ? STALL_ROB : STALL_RS;
  end
  assign stall_cause = stall;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_v  <= 1'b0;
      tail    <= '0;
      rob_cnt <= '0;
    end else begin
      // A newly accepted entry replaces the one firing this cycle; invalid ones never occupy it.
      if (accept)    hold_v <= dec_ok;
      else if (fire) hold_v <= 1'b0;
      if (fire) tail <= tail + 1'b1;
      case ({fire, commit_ok})
        2'b10:   rob_cnt <= rob_cnt + 1'b1;
        2'b01:   rob_cnt <= rob_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_fu      <= FU_NONE;
      hold_payload <= '0;
      ill_q        <= 1'b0;
    end else begin
      ill_q <= accept && !dec_ok;
      if (accept && dec_ok) begin
        hold_fu      <= fu_e'(dec_futype);
        hold_payload <= dec_payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      commit_underflow: assert (!(rob_commit && rob_cnt == '0));
      credit_bound: assert (alu_credit <= ALU_MAX && lsq_credit <= LSQ_MAX &&
                            bra_credit <= BRA_MAX);
    end
  end

  rs_credit_counter #(.DEPTH(ALU_RS_DEPTH), .W(ALU_CW)) u_alu_cred (
    .clk(clk), .rst(rst), .inc(alu_free), .dec(alu_valid), .restore(flush),
    .credit(alu_credit), .nonzero(alu_nz)
  );

  rs_credit_counter #(.DEPTH(LSQ_DEPTH), .W(LSQ_CW)) u_lsq_cred (
    .clk(clk), .rst(rst), .inc(lsq_free), .dec(lsq_valid), .restore(flush),
    .credit(lsq_credit), .nonzero(lsq_nz)
  );

  rs_credit_counter #(.DEPTH(BRA_RS_DEPTH), .W(BRA_CW)) u_bra_cred (
    .clk(clk), .rst(rst), .inc(bra_free), .dec(bra_valid), .restore(flush),
    .credit(bra_credit), .nonzero(bra_nz)
  );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue/counter level model.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int ROB_D = 16;
  localparam int ALU_D = 4;
  localparam int LSQ_D = 4;
  localparam int BRA_D = 4;

  logic        clk, rst, flush, dec_valid, dec_ready, dec_rob_we;
  logic [2:0]  dec_futype;
  logic [63:0] dec_payload, disp_payload;
  logic        rob_commit, alu_free, lsq_free, bra_free;
  logic        alu_valid, lsq_valid, bra_valid, rob_alloc, ill_inst;
  logic [3:0]  disp_rob_tag;
  logic [1:0]  stall_cause;

  int n_tests = 0;
  int n_fail  = 0;

  dispatch_ctrl #(.LSQ_DEPTH(LSQ_D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_futype(dec_futype), .dec_rob_we(dec_rob_we), .dec_payload(dec_payload),
    .rob_commit(rob_commit), .alu_free(alu_free), .lsq_free(lsq_free), .bra_free(bra_free),
    .alu_valid(alu_valid), .lsq_valid(lsq_valid), .bra_valid(bra_valid),
    .disp_payload(disp_payload), .disp_rob_tag(disp_rob_tag), .rob_alloc(rob_alloc),
    .ill_inst(ill_inst), .stall_cause(stall_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_known = 1'b0;
  bit          m_hold;
  int          m_fu;
  logic [63:0] m_pay;
  int          m_tail, m_cnt;
  int          m_cred[3];
  bit          m_ill;
  int          depth[3] = '{ALU_D, LSQ_D, BRA_D};

  function automatic int fu_idx(input logic [2:0] fu);
    case (fu)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  initial begin
    forever begin
      bit e_fire, e_ready, acc, ok;
      int e_stall, cnt0;
      int cred0[3];
      bit frees[3];
      @(negedge clk);
      #2;
      if (m_known) begin
        e_fire  = m_hold && !flush && (m_cnt < ROB_D) && (m_cred[m_fu] > 0);
        e_ready = !flush && (!m_hold || e_fire);
        e_stall = (m_hold && !flush && !e_fire) ? ((m_cnt == ROB_D) ? 1 : 2) : 0;
        check("dec_ready", 64'(dec_ready), 64'(e_ready));
        check("alu_valid", 64'(alu_valid), 64'(e_fire && m_fu == 0));
        check("lsq_valid", 64'(lsq_valid), 64'(e_fire && m_fu == 1));
        check("bra_valid", 64'(bra_valid), 64'(e_fire && m_fu == 2));
        check("rob_alloc", 64'(rob_alloc), 64'(e_fire));
        check("rob_tag",   64'(disp_rob_tag), 64'(m_tail));
        check("ill_inst",  64'(ill_inst), 64'(m_ill));
        check("stall",     64'(stall_cause), 64'(e_stall));
        if (e_fire) check("payload", disp_payload, m_pay);

        if (rst || flush) begin
          m_hold = 0; m_tail = 0; m_cnt = 0; m_ill = 0;
          m_cred = '{ALU_D, LSQ_D, BRA_D};
        end else begin
          acc   = dec_valid && e_ready;
          ok    = dec_rob_we && (fu_idx(dec_futype) >= 0);
          cnt0  = m_cnt;
          cred0 = m_cred;
          frees = '{alu_free, lsq_free, bra_free};
          if (e_fire) begin
            m_tail = (m_tail + 1) % ROB_D;
            m_cnt++;
            m_cred[m_fu]--;
          end
          if (rob_commit && cnt0 > 0) m_cnt--;
          for (int k = 0; k < 3; k++)
            if (frees[k] && cred0[k] < depth[k]) m_cred[k]++;
          m_ill = acc && !ok;
          if (acc) begin
            m_hold = ok;
            if (ok) begin
              m_fu  = fu_idx(dec_futype);
              m_pay = dec_payload;
            end
          end else if (e_fire) begin
            m_hold = 0;
          end
        end
      end else if (rst) begin
        m_known = 1'b1;
        m_hold = 0; m_tail = 0; m_cnt = 0; m_ill = 0; m_fu = 0; m_pay = '0;
        m_cred = '{ALU_D, LSQ_D, BRA_D};
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    rst = 0; flush = 0; dec_valid = 0; dec_futype = 3'b000; dec_rob_we = 0;
    dec_payload = '0; rob_commit = 0; alu_free = 0; lsq_free = 0; bra_free = 0;
  endtask

  task automatic next();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic send(input logic [2:0] fu, input logic [63:0] pay);
    dec_valid = 1; dec_futype = fu; dec_rob_we = 1; dec_payload = pay;
  endtask

  task automatic do_flush();
    next(); flush = 1; #3;
    check("flush_ready", 64'(dec_ready), 64'd0);
  endtask

  // 17 ALU instructions with credit returns: leaves the 17th held by a full ROB.
  task automatic fill17();
    for (int i = 0; i < 17; i++) begin
      next(); send(FU_ALU, 64'h100 + 64'(i));
      if (i >= 2) alu_free = 1;
    end
    next(); #3;
    check("fill_stall", 64'(stall_cause), 64'd1);
    check("fill_ready", 64'(dec_ready), 64'd0);
    check("fill_noval", 64'(alu_valid), 64'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    next(); rst = 1;
    next(); #3;
    check("rst_ready", 64'(dec_ready), 64'd1);
    check("rst_alloc", 64'(rob_alloc), 64'd0);
    check("rst_tag",   64'(disp_rob_tag), 64'd0);
    check("rst_stall", 64'(stall_cause), 64'd0);
    check("rst_ill",   64'(ill_inst), 64'd0);

    // Three back-to-back ALU instructions
    next(); send(FU_ALU, 64'hA0); #3;
    check("t1_c0_valid", 64'(alu_valid), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      next();
      if (i < 3) send(FU_ALU, 64'hA0 + 64'(i));
      #3;
      check("t1_valid", 64'(alu_valid), 64'd1);
      check("t1_tag", 64'(disp_rob_tag), 64'(i - 1));
      check("t1_payload", disp_payload, 64'hA0 + 64'(i - 1));
      check("t1_ready", 64'(dec_ready), 64'd1);
    end
    do_flush();

    // LSQ credit exhaustion with LSQ depth 4
    for (int i = 0; i < 5; i++) begin
      next(); send(FU_LSQ, 64'hB0 + 64'(i));
    end
    next(); #3;
    check("t2_stall", 64'(stall_cause), 64'd2);
    check("t2_ready", 64'(dec_ready), 64'd0);
    check("t2_noval", 64'(lsq_valid), 64'd0);
    next(); lsq_free = 1; #3;
    check("t2_free_stall", 64'(stall_cause), 64'd2);
    next(); #3;
    check("t2_valid", 64'(lsq_valid), 64'd1);
    check("t2_tag", 64'(disp_rob_tag), 64'd4);
    check("t2_payload", disp_payload, 64'hB4);
    do_flush();

    // ROB full, then commit + free releases the 17th with a wrapped tag
    fill17();
    next(); rob_commit = 1; alu_free = 1; #3;
    check("t3_still_stall", 64'(stall_cause), 64'd1);
    next(); #3;
    check("t3_valid", 64'(alu_valid), 64'd1);
    check("t3_tag", 64'(disp_rob_tag), 64'd0);
    do_flush();

    // Invalid instruction consumes nothing
    next(); dec_valid = 1; dec_futype = 3'b000; dec_rob_we = 0; #3;
    check("t4_ready", 64'(dec_ready), 64'd1);
    next(); send(FU_BRA, 64'hC0); #3;
    check("t4_ill", 64'(ill_inst), 64'd1);
    check("t4_noalloc", 64'(rob_alloc), 64'd0);
    check("t4_tag", 64'(disp_rob_tag), 64'd0);
    next(); #3;
    check("t4_ill_off", 64'(ill_inst), 64'd0);
    check("t4_bra", 64'(bra_valid), 64'd1);
    check("t4_bra_tag", 64'(disp_rob_tag), 64'd0);

    // Flush while held by a full ROB
    do_flush();
    fill17();
    do_flush();
    check("t5_flush_noval", 64'(alu_valid), 64'd0);
    next(); send(FU_ALU, 64'hD0); #3;
    check("t5_cnt", 64'(dut.rob_cnt), 64'd0);
    check("t5_tail", 64'(dut.tail), 64'd0);
    check("t5_alu_cred", 64'(dut.u_alu_cred.credit), 64'(ALU_D));
    check("t5_lsq_cred", 64'(dut.u_lsq_cred.credit), 64'(LSQ_D));
    check("t5_bra_cred", 64'(dut.u_bra_cred.credit), 64'(BRA_D));
    next(); #3;
    check("t5_valid", 64'(alu_valid), 64'd1);
    check("t5_tag", 64'(disp_rob_tag), 64'd0);
    do_flush();

    // Fire + commit + free together leave counters where they were
    next(); send(FU_ALU, 64'hE0);
    next(); send(FU_ALU, 64'hE1);
    next(); rob_commit = 1; alu_free = 1; #3;
    check("t6_valid", 64'(alu_valid), 64'd1);
    check("t6_tag", 64'(disp_rob_tag), 64'd1);
    next(); #3;
    check("t6_cnt", 64'(dut.rob_cnt), 64'd1);
    check("t6_cred", 64'(dut.u_alu_cred.credit), 64'(ALU_D - 1));

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      next();
      if ($urandom_range(0, 499) == 0) rst = 1;
      if ($urandom_range(0, 59) == 0) flush = 1;
      dec_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:          dec_futype = 3'b000;
        1, 2, 3, 4: dec_futype = FU_ALU;
        5, 6, 7:    dec_futype = FU_LSQ;
        default:    dec_futype = FU_BRA;
      endcase
      dec_rob_we  = ($urandom_range(0, 11) != 0);
      dec_payload = {$urandom, $urandom};
      rob_commit  = (m_cnt > 0) && ($urandom_range(0, 4) == 0);
      alu_free    = (m_cred[0] < ALU_D) && ($urandom_range(0, 2) == 0);
      lsq_free    = (m_cred[1] < LSQ_D) && ($urandom_range(0, 2) == 0);
      bra_free    = (m_cred[2] < BRA_D) && ($urandom_range(0, 2) == 0);
    end

    next(); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
